// File: rtl/alu_rs_if.sv
// alu_rs_if: issue, CDB snoop and ALU dispatch signals of the ALU reservation station
interface alu_rs_if;
    logic        rdy;
    logic        rollback;
    logic        issue_en;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic [31:0] issue_imm;
    logic [31:0] issue_pc;
    logic [3:0]  issue_rob_pos;
    logic        issue_q1_valid;
    logic [3:0]  issue_q1;
    logic [31:0] issue_val1;
    logic        issue_q2_valid;
    logic [3:0]  issue_q2;
    logic [31:0] issue_val2;
    logic        rs_full;
    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        lsb_result;
    logic [3:0]  lsb_result_rob_pos;
    logic [31:0] lsb_result_val;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;
    modport master (
        output rdy, rollback, issue_en, issue_opcode, issue_funct3, issue_funct7, issue_imm, issue_pc,
               issue_rob_pos, issue_q1_valid, issue_q1, issue_val1, issue_q2_valid, issue_q2, issue_val2,
               alu_result, alu_result_rob_pos, alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val,
        input  rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );
    modport slave (
        input  rdy, rollback, issue_en, issue_opcode, issue_funct3, issue_funct7, issue_imm, issue_pc,
               issue_rob_pos, issue_q1_valid, issue_q1, issue_val1, issue_q2_valid, issue_q2, issue_val2,
               alu_result, alu_result_rob_pos, alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val,
        output rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station snooping ALU/LSB CDBs, one registered dispatch per cycle.
// Optional ALU_RS_FAST_WAKEUP_EN: select also sees operands arriving on the CDB this cycle.
module alu_rs #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input logic       clk,
    input logic       rst,
    alu_rs_if.slave   b
);
    logic [ENTRIES-1:0] busy_q, busy_d, q1v_q, q1v_d, q2v_q, q2v_d, wq1v, wq2v, ready;
    logic [6:0]  op_q [ENTRIES], op_d [ENTRIES];
    logic [2:0]  f3_q [ENTRIES], f3_d [ENTRIES];
    logic        f7_q [ENTRIES], f7_d [ENTRIES];
    logic [31:0] imm_q [ENTRIES], imm_d [ENTRIES];
    logic [31:0] pc_q [ENTRIES], pc_d [ENTRIES];
    logic [3:0]  rob_q [ENTRIES], rob_d [ENTRIES];
    logic [3:0]  q1_q [ENTRIES], q1_d [ENTRIES];
    logic [3:0]  q2_q [ENTRIES], q2_d [ENTRIES];
    logic [31:0] v1_q [ENTRIES], v1_d [ENTRIES], w1 [ENTRIES];
    logic [31:0] v2_q [ENTRIES], v2_d [ENTRIES], w2 [ENTRIES];
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic        free_ok, sel_ok;
    logic        aen_q, aen_d, af7_q, af7_d;
    logic [6:0]  aop_q, aop_d;
    logic [2:0]  af3_q, af3_d;
    logic [31:0] av1_q, av1_d, av2_q, av2_d, aimm_q, aimm_d, apc_q, apc_d;
    logic [3:0]  arob_q, arob_d;
    logic        cav, clv;
    logic [3:0]  cat, clt;
    logic [31:0] cad, cld;
    logic [32:0] is1, is2;
    assign {cav, cat, cad} = {b.alu_result, b.alu_result_rob_pos, b.alu_result_val};
    assign {clv, clt, cld} = {b.lsb_result, b.lsb_result_rob_pos, b.lsb_result_val};
    // {hit, value}; the ALU bus wins if both carry the same tag
    function automatic logic [32:0] snoop(input logic [3:0] t);
        return (cav && cat == t) ? {1'b1, cad} : (clv && clt == t) ? {1'b1, cld} : 33'd0;
    endfunction
    for (genvar i = 0; i < ENTRIES; i++) begin : g_wake
        logic [32:0] s1, s2;
        assign s1 = snoop(q1_q[i]);
        assign s2 = snoop(q2_q[i]);
        assign wq1v[i] = q1v_q[i] && !s1[32];
        assign wq2v[i] = q2v_q[i] && !s2[32];
        assign w1[i] = (q1v_q[i] && s1[32]) ? s1[31:0] : v1_q[i];
        assign w2[i] = (q2v_q[i] && s2[32]) ? s2[31:0] : v2_q[i];
    end
`ifdef ALU_RS_FAST_WAKEUP_EN
    assign ready = busy_q & ~wq1v & ~wq2v;
`else
    assign ready = busy_q & ~q1v_q & ~q2v_q;
`endif
    assign is1 = snoop(b.issue_q1);
    assign is2 = snoop(b.issue_q2);
    assign b.rs_full = &busy_q;
    always_comb begin
        free_ok = 1'b0;
        free_idx = '0;
        sel_ok = 1'b0;
        sel_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_ok = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ready[i]) begin
                sel_ok = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end
    always_comb begin
        busy_d = busy_q;
        q1v_d = wq1v;
        q2v_d = wq2v;
        v1_d = w1;
        v2_d = w2;
        op_d = op_q;
        f3_d = f3_q;
        f7_d = f7_q;
        imm_d = imm_q;
        pc_d = pc_q;
        rob_d = rob_q;
        q1_d = q1_q;
        q2_d = q2_q;
        if (sel_ok) busy_d[sel_idx] = 1'b0;
        if (b.issue_en && free_ok) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx] = b.issue_opcode;
            f3_d[free_idx] = b.issue_funct3;
            f7_d[free_idx] = b.issue_funct7;
            imm_d[free_idx] = b.issue_imm;
            pc_d[free_idx] = b.issue_pc;
            rob_d[free_idx] = b.issue_rob_pos;
            q1_d[free_idx] = b.issue_q1;
            q2_d[free_idx] = b.issue_q2;
            q1v_d[free_idx] = b.issue_q1_valid && !is1[32];
            q2v_d[free_idx] = b.issue_q2_valid && !is2[32];
            v1_d[free_idx] = (b.issue_q1_valid && is1[32]) ? is1[31:0] : b.issue_val1;
            v2_d[free_idx] = (b.issue_q2_valid && is2[32]) ? is2[31:0] : b.issue_val2;
        end
        if (b.rollback) busy_d = '0;
        aen_d = sel_ok && !b.rollback;
        aop_d = aen_d ? op_q[sel_idx] : aop_q;
        af3_d = aen_d ? f3_q[sel_idx] : af3_q;
        af7_d = aen_d ? f7_q[sel_idx] : af7_q;
        aimm_d = aen_d ? imm_q[sel_idx] : aimm_q;
        apc_d = aen_d ? pc_q[sel_idx] : apc_q;
        arob_d = aen_d ? rob_q[sel_idx] : arob_q;
        av1_d = aen_d ? w1[sel_idx] : av1_q;
        av2_d = aen_d ? w2[sel_idx] : av2_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            aen_q <= 1'b0;
            aop_q <= '0;
            af3_q <= '0;
            af7_q <= 1'b0;
            aimm_q <= '0;
            apc_q <= '0;
            arob_q <= '0;
            av1_q <= '0;
            av2_q <= '0;
        end else if (b.rdy) begin
            busy_q <= busy_d;
            aen_q <= aen_d;
            aop_q <= aop_d;
            af3_q <= af3_d;
            af7_q <= af7_d;
            aimm_q <= aimm_d;
            apc_q <= apc_d;
            arob_q <= arob_d;
            av1_q <= av1_d;
            av2_q <= av2_d;
        end
    end
    always_ff @(posedge clk) begin
        if (b.rdy) begin
            q1v_q <= q1v_d;
            q2v_q <= q2v_d;
            op_q <= op_d;
            f3_q <= f3_d;
            f7_q <= f7_d;
            imm_q <= imm_d;
            pc_q <= pc_d;
            rob_q <= rob_d;
            q1_q <= q1_d;
            q2_q <= q2_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end
    assign b.alu_en = aen_q;
    assign b.alu_opcode = aop_q;
    assign b.alu_funct3 = af3_q;
    assign b.alu_funct7 = af7_q;
    assign b.alu_imm = aimm_q;
    assign b.alu_pc = apc_q;
    assign b.alu_rob_pos = arob_q;
    assign b.alu_val1 = av1_q;
    assign b.alu_val2 = av2_q;
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station feeding the integer ALU in the out-of-order core. Holds up to ENTRIES issued ALU/branch/jump/LUI/AUIPC instructions and snoops both common data buses (ALU and LSB) to resolve operand tags. Each cycle it dispatches at most one operand-ready instruction to the ALU as a registered one-cycle `alu_en` packet. Sits between the decoder/issue stage and the ALU.

## Interface

Parameters:

- ENTRIES, default 16: number of station slots. Must be a power of two.
- IDX_W, default 4: log2(ENTRIES).

Ports (widths: DATA 32, ADDR 32, ROB_POS 4, OPCODE 7, FUNCT3 3):

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low freezes all state and outputs
- rollback  in  1  misprediction flush
- issue_en  in  1  new instruction this cycle
- issue_opcode  in  7  instruction opcode
- issue_funct3  in  3  instruction funct3
- issue_funct7  in  1  funct7 bit
- issue_imm  in  32  immediate
- issue_pc  in  32  instruction PC
- issue_rob_pos  in  4  destination ROB slot
- issue_q1_valid  in  1  1 = rs1 still pending
- issue_q1  in  4  producer ROB slot for rs1
- issue_val1  in  32  rs1 value, used when q1 is not valid
- issue_q2_valid  in  1  1 = rs2 still pending
- issue_q2  in  4  producer ROB slot for rs2
- issue_val2  in  32  rs2 value, used when q2 is not valid
- rs_full  out  1  combinational; all entries busy
- alu_result, alu_result_rob_pos, alu_result_val  in  1/4/32  ALU CDB
- lsb_result, lsb_result_rob_pos, lsb_result_val  in  1/4/32  LSB CDB
- alu_en  out  1  dispatch strobe to the ALU
- alu_opcode, alu_funct3, alu_funct7  out  7/3/1  dispatched instruction fields
- alu_val1, alu_val2, alu_imm, alu_pc  out  32 each  dispatched operands, immediate and PC
- alu_rob_pos  out  4  dispatched destination ROB slot

## Operation

- Entry fields: busy, opcode, funct3, funct7, imm, pc, rob_pos, q1_valid, q1, v1, q2_valid, q2, v2.
- Allocation: when `issue_en` is high, write into the lowest-index free entry.
- Issuing while `rs_full` is high is illegal. The instruction is dropped, and the bench flags it.
- Issue bypass: if `issue_q1_valid` is high and `issue_q1` matches a valid CDB tag in the same cycle, store that CDB value and clear q1_valid. The same rule applies to q2.
- If both CDBs match the same tag, ALU-CDB priority applies. Both CDBs matching one tag is illegal upstream.
- Wakeup: every busy entry with q*_valid high and q* equal to a valid CDB tag captures the value and clears q*_valid at the clock edge.
- Ready: an entry is ready when busy && !q1_valid && !q2_valid, evaluated on registered state.
- Select: the lowest-index ready entry is dispatched. Its fields are registered onto the alu_* outputs, `alu_en` is driven high for one cycle, and the entry's busy bit is cleared at the same edge.
- Allocation and dispatch may occur in the same cycle. The freed slot is not reusable until the next cycle.
- Operand fields go out unchanged. Opcode-specific use (imm vs val2, pc) is decided by the ALU.
- Rollback: clear every busy bit and deassert `alu_en` at the next edge. Any issue in that cycle is discarded.
- Reset: identical to rollback. In addition, all alu_* data outputs go to 0.
- `rdy` low: no allocation, wakeup or dispatch. All registers, including `alu_en`, hold their value. CDB inputs are ignored.

## Timing

- Reset values: `alu_en` 0, all alu_* 0. `rs_full` reads 0 after reset because it is derived from the busy bits.
- Issue with both operands ready at edge N: the entry is busy after N, and `alu_en` is high in the cycle after edge N+1. Minimum latency is 2 edges.
- Dependent wakeup: CDB valid in cycle M. With the default configuration, `alu_en` is high after edge M+2.
- Each dispatch holds `alu_en` high for exactly one rdy-qualified cycle. A new packet may follow every cycle.
- `rs_full` is combinational from the busy vector, so it updates the cycle after allocation or dispatch.

## Configuration

- ALU_RS_FAST_WAKEUP_EN defined: the ready check also treats an operand as ready when its tag matches a valid CDB in the current cycle. The dispatched value is muxed from the CDB. Dependent dispatch `alu_en` is then high after edge M+1, one cycle earlier. The issue bypass is unchanged.
- Macro undefined: ready uses registered state only, as described above.

## Test plan

- Reset, then issue ADDI (rob_pos 3, val1 5, imm 7, no deps) -> `alu_en` pulses once, 2 edges later, with alu_val1=5, alu_imm=7, alu_rob_pos=3.
- Issue an ADD with q1=2 pending; 3 cycles later drive alu_result with rob_pos 2, val 0x10 -> dispatch at M+2 (M+1 with the macro) with alu_val1=0x10.
- Issue an instruction with q2=5 in the same cycle lsb_result tag 5 carries 0xABCD -> stored via the issue bypass; dispatches with alu_val2=0xABCD and never waits.
- Fill all 16 entries with blocked instructions -> `rs_full`=1 and no `alu_en`. One wakeup -> exactly one dispatch, then `rs_full`=0 the cycle after.
- Four ready entries, with `rdy` low for 3 cycles mid-stream -> dispatch order is by index 0,1,2,3. `alu_en` and the alu_* outputs are held during the stall, and no packet is lost or duplicated.
- With 5 entries busy, assert `rollback` for one cycle while `issue_en` is also high -> zero busy entries afterwards, `alu_en`=0, and no dispatch occurs until new issues arrive.
